// File: rtl/ram_rw_sched_pkg.sv
// Shared types and constants for the RAM write/read sequencing controller.
package ram_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_e;

    // 0.2 s dwell per read address at 50 MHz
    localparam int unsigned CNT_MAX_DEF = 24'd9_999_999;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ram_rw_sched_if.sv
// Key-flag, RAM and display-side signals of the sequencing controller.
interface ram_rw_sched_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);
    logic              wr_flag;
    logic              rd_flag;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;

    modport master (
        input  wr_flag, rd_flag, rd_data,
        output wr_en, rd_en, addr, wr_data, data_out, data_valid
    );

    modport slave (
        output wr_flag, rd_flag, rd_data,
        input  wr_en, rd_en, addr, wr_data, data_out, data_valid
    );
endinterface

// File: rtl/ram_rw_sched_dwell_cnt.sv
// Dwell counter: counts 0..CNT_MAX while enabled, pulses dwell_end on the last count.
module dwell_cnt
    import ram_sched_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic dwell_end
);
    localparam int unsigned CW = cnt_width(CNT_MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    assign dwell_end = en && !clr && (cnt_q == CW'(CNT_MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = dwell_end ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/ram_rw_sched.sv
// Fills the RAM with an address pattern on a write request and scans it back
// one address per dwell period on a read request, arbitrating the two keys.
module ram_rw_sched
    import ram_sched_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    ram_rw_sched_if.master  bus
);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_pend_q, rd_pend_d;
    logic              stg0_q, stg0_d;
    logic              stg1_q, stg1_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              flush;
    logic              capture;
    logic              dwell_end;

    dwell_cnt #(.CNT_MAX(CNT_MAX)) u_dwell (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .en        (state_q == READ),
        .clr       ((state_q != READ) || bus.wr_flag || bus.rd_flag),
        .dwell_end (dwell_end)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rd_pend_d = rd_pend_q;
        stg0_d    = 1'b0;
        stg1_d    = stg0_q;
        flush     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_flag) begin
                    state_d   = WRITE;
                    addr_d    = '0;
                    rd_pend_d = bus.rd_flag;
                end else if (bus.rd_flag) begin
                    state_d = READ;
                    addr_d  = '0;
                    stg0_d  = 1'b1;
                end
            end
            WRITE: begin
                addr_d = addr_q + 1'b1;
                if (bus.rd_flag) begin
                    rd_pend_d = 1'b1;
                end
                if (addr_q == ADDR_LAST) begin
                    addr_d = '0;
                    // a read key arriving on the last write cycle still counts
                    if (rd_pend_q || bus.rd_flag) begin
                        state_d   = READ;
                        rd_pend_d = 1'b0;
                        stg0_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            READ: begin
                if (bus.wr_flag) begin
                    state_d   = WRITE;
                    addr_d    = '0;
                    rd_pend_d = bus.rd_flag;
                    flush     = 1'b1;
                end else if (bus.rd_flag) begin
                    addr_d = '0;
                    flush  = 1'b1;
                    stg0_d = 1'b1;
                end else if (dwell_end) begin
                    addr_d = addr_q + 1'b1;
                    stg0_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // strobes of an aborted or restarted scan, including one due this edge, are dropped
        if (flush) begin
            stg1_d = 1'b0;
        end
        capture      = stg1_q && !flush;
        data_out_d   = capture ? bus.rd_data : data_out_q;
        data_valid_d = capture;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rd_pend_q    <= 1'b0;
            stg0_q       <= 1'b0;
            stg1_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rd_pend_q    <= rd_pend_d;
            stg0_q       <= stg0_d;
            stg1_q       <= stg1_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign bus.wr_en      = (state_q == WRITE);
    assign bus.rd_en      = (state_q == READ);
    assign bus.addr       = addr_q;
    assign bus.wr_data    = DATA_W'(addr_q);
    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
endmodule

// File: tb/tb_ram_rw_sched.sv
// Directed bench for ram_rw_sched with a 1-cycle registered 256x8 RAM model.
module tb_ram_rw_sched;
    import ram_sched_pkg::*;

    logic sys_clk;
    logic sys_rst_n;
    int   n_checks;
    int   n_errors;
    int   dv_cnt;
    int   dv0;

    logic [7:0] mem [256];

    ram_rw_sched_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    ram_rw_sched #(.ADDR_W(8), .DATA_W(8), .CNT_MAX(9)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.master)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (bus.wr_en) mem[bus.addr] <= bus.wr_data;
        if (bus.rd_en) bus.rd_data <= mem[bus.addr];
    end

    always @(negedge sys_clk) begin
        if (bus.data_valid) dv_cnt <= dv_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse(input logic w, input logic r);
        bus.wr_flag = w;
        bus.rd_flag = r;
        @(posedge sys_clk);
        #1;
        bus.wr_flag = 1'b0;
        bus.rd_flag = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wen"}, bus.wr_en, 0);
        check({tag, "_ren"}, bus.rd_en, 0);
        check({tag, "_addr"}, bus.addr, 0);
        check({tag, "_wdata"}, bus.wr_data, 0);
        check({tag, "_dout"}, bus.data_out, 0);
        check({tag, "_dv"}, bus.data_valid, 0);
        check({tag, "_state"}, dut.state_q, IDLE);
        check({tag, "_pend"}, dut.rd_pend_q, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        dv_cnt      = 0;
        sys_rst_n   = 1'b0;
        bus.wr_flag = 1'b0;
        bus.rd_flag = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        tick(3);
        check_reset_vals("por");
        sys_rst_n = 1'b1;
        tick(2);

        // unwritten RAM reads back init content
        pulse(0, 1);
        check("ini_ren", bus.rd_en, 1);
        check("ini_addr", bus.addr, 0);
        tick(2);
        check("ini_dv0", bus.data_valid, 1);
        check("ini_d0", bus.data_out, 0);
        tick(10);
        check("ini_dv1", bus.data_valid, 1);
        check("ini_a1", bus.addr, 1);
        check("ini_d1", bus.data_out, 0);

        // async reset mid-read
        tick(3);
        sys_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_rd");
        tick(1);
        sys_rst_n = 1'b1;
        tick(1);

        // full fill
        dv0 = dv_cnt;
        pulse(1, 0);
        for (int i = 0; i < 256; i++) begin
            check("fill_addr", bus.addr, i);
            check("fill_wdata", bus.wr_data, i);
            check("fill_wen", bus.wr_en, 1);
            check("fill_ren", bus.rd_en, 0);
            tick(1);
        end
        check("fill_end_wen", bus.wr_en, 0);
        check("fill_end_ren", bus.rd_en, 0);
        check("fill_end_addr", bus.addr, 0);
        check("fill_end_dout", bus.data_out, 0);
        check("fill_no_dv", dv_cnt, dv0);

        // scan with wrap 255 -> 0
        pulse(0, 1);
        check("scan_addr0", bus.addr, 0);
        check("scan_ren", bus.rd_en, 1);
        check("scan_dv_c0", bus.data_valid, 0);
        tick(1);
        check("scan_dv_c1", bus.data_valid, 0);
        tick(1);
        check("scan_dv_first", bus.data_valid, 1);
        check("scan_d_first", bus.data_out, 0);
        for (int k = 1; k <= 256; k++) begin
            tick(9);
            check("scan_dv_gap", bus.data_valid, 0);
            tick(1);
            check("scan_dv", bus.data_valid, 1);
            check("scan_dout", bus.data_out, k % 256);
            check("scan_addr", bus.addr, k % 256);
        end

        // restart, then restart again with a capture of addr 37 pending
        pulse(0, 1);
        check("rs_addr", bus.addr, 0);
        check("rs_dv", bus.data_valid, 0);
        tick(2);
        check("rs_dv2", bus.data_valid, 1);
        check("rs_d2", bus.data_out, 0);
        tick(369);
        check("rs37_addr", bus.addr, 37);
        check("rs37_dout", bus.data_out, 36);
        pulse(0, 1);
        check("rs37_a0", bus.addr, 0);
        check("rs37_flush", bus.data_valid, 0);
        check("rs37_hold", bus.data_out, 36);
        tick(1);
        check("rs37_flush2", bus.data_valid, 0);
        check("rs37_hold2", bus.data_out, 36);
        tick(1);
        check("rs37_dv", bus.data_valid, 1);
        check("rs37_d0", bus.data_out, 0);

        // write key aborts a read at addr 100
        tick(999);
        check("ab_addr", bus.addr, 100);
        check("ab_dout", bus.data_out, 99);
        pulse(1, 0);
        check("ab_wen", bus.wr_en, 1);
        check("ab_ren", bus.rd_en, 0);
        check("ab_addr0", bus.addr, 0);
        check("ab_dv", bus.data_valid, 0);
        check("ab_hold", bus.data_out, 99);
        dv0 = dv_cnt;
        tick(1);
        check("ab_addr1", bus.addr, 1);
        check("ab_hold1", bus.data_out, 99);
        tick(254);
        check("ab_last", bus.addr, 255);
        tick(1);
        check("ab_idle_wen", bus.wr_en, 0);
        check("ab_idle_ren", bus.rd_en, 0);
        check("ab_idle_dout", bus.data_out, 99);
        check("ab_no_dv", dv_cnt, dv0);

        // simultaneous keys from IDLE: fill then read
        pulse(1, 1);
        check("sim_wen", bus.wr_en, 1);
        check("sim_addr", bus.addr, 0);
        tick(255);
        check("sim_last", bus.addr, 255);
        check("sim_last_wen", bus.wr_en, 1);
        tick(1);
        check("sim_ren", bus.rd_en, 1);
        check("sim_wen0", bus.wr_en, 0);
        check("sim_a0", bus.addr, 0);
        tick(2);
        check("sim_dv", bus.data_valid, 1);
        check("sim_d0", bus.data_out, 0);
        tick(10);
        check("sim_d1", bus.data_out, 1);

        // read key mid-fill is deferred; write key mid-fill is ignored
        pulse(1, 0);
        check("pd_wen", bus.wr_en, 1);
        check("pd_addr0", bus.addr, 0);
        tick(50);
        check("pd_addr50", bus.addr, 50);
        pulse(0, 1);
        check("pd_addr51", bus.addr, 51);
        check("pd_wen51", bus.wr_en, 1);
        check("pd_pend", dut.rd_pend_q, 1);
        tick(49);
        pulse(1, 0);
        check("pd_norestart", bus.addr, 101);
        check("pd_wen101", bus.wr_en, 1);
        tick(154);
        check("pd_last", bus.addr, 255);
        check("pd_last_wen", bus.wr_en, 1);
        tick(1);
        check("pd_ren", bus.rd_en, 1);
        check("pd_a0", bus.addr, 0);
        check("pd_pend_clr", dut.rd_pend_q, 0);
        tick(2);
        check("pd_dv", bus.data_valid, 1);
        check("pd_d0", bus.data_out, 0);

        // async reset mid-write with a pending read
        pulse(1, 1);
        tick(20);
        check("rw_addr", bus.addr, 20);
        check("rw_pend", dut.rd_pend_q, 1);
        sys_rst_n = 1'b0;
        #1;
        check_reset_vals("rst_wr");
        tick(1);
        sys_rst_n = 1'b1;
        tick(300);
        check("rw_stay_ren", bus.rd_en, 0);
        check("rw_stay_wen", bus.wr_en, 0);
        pulse(0, 1);
        tick(2);
        check("rw_rd_dv", bus.data_valid, 1);
        check("rw_rd_d0", bus.data_out, 0);
        tick(10);
        check("rw_rd_d1", bus.data_out, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
